// File: rtl/id_issue_ctrl_pkg.sv
// Shared encodings for the ID issue controller: FSM state codes and scoreboard sizing.
package id_issue_ctrl_pkg;

  localparam int NREG  = 32;
  localparam int IDX_W = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam logic [0:0] D_IDLE  = 1'b0;
  localparam logic [0:0] D_BUSY  = 1'b1;

  localparam logic [0:0] T_IDLE  = 1'b0;
  localparam logic [0:0] T_DRAIN = 1'b1;

  function automatic logic is_long_op(input logic is_load, input logic div_en);
    return is_load | div_en;
  endfunction

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// Pending-writeback bit per architectural register; x0 is never tracked.
module scoreboard #(
  parameter int NREG = id_issue_ctrl_pkg::NREG
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_set_en,
  input  logic [4:0] i_set_idx,
  input  logic       i_clr_en,
  input  logic [4:0] i_clr_idx,
  input  logic [4:0] i_rs1_idx,
  input  logic [4:0] i_rs2_idx,
  input  logic [4:0] i_rd_idx,
  output logic       o_rs1_pend,
  output logic       o_rs2_pend,
  output logic       o_rd_pend,
  output logic       o_any_pend
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  // Set is applied after clear so a new producer wins over an older op's writeback.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en) w_pend_nxt[i_clr_idx] = 1'b0;
    if (i_set_en) w_pend_nxt[i_set_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  assign o_rs1_pend = (i_rs1_idx != '0) & r_pend[i_rs1_idx];
  assign o_rs2_pend = (i_rs2_idx != '0) & r_pend[i_rs2_idx];
  assign o_rd_pend  = (i_rd_idx  != '0) & r_pend[i_rd_idx];
  assign o_any_pend = |r_pend;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue/stall decision, divider sequencing and trap drain/serialisation.
module id_issue_ctrl #(
  parameter int NREG  = id_issue_ctrl_pkg::NREG,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       rs1_idx_i,
  input  logic [4:0]       rs2_idx_i,
  input  logic [4:0]       rd_idx_i,
  input  logic             wben_i,
  input  logic             is_load_i,
  input  logic             div_en_i,
  input  logic             trap_i,
  input  logic             flush_i,
  input  logic             wb_wren_i,
  input  logic [4:0]       wb_rdid_i,
  input  logic             wb_long_i,
  input  logic             div_done_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic             div_start_o,
  output logic             div_busy_o,
  output logic             trap_fire_o,
  output logic             drain_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import id_issue_ctrl_pkg::*;

  logic [0:0]       r_dstate;
  logic [0:0]       r_tstate;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rs1_pend, w_rs2_pend, w_rd_pend, w_any_pend;
  logic w_live, w_long, w_hazard, w_waw, w_struct;
  logic w_drained, w_trap_block;
  logic w_sb_set, w_sb_clr;

  scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_sb_set),
    .i_set_idx  (rd_idx_i),
    .i_clr_en   (w_sb_clr),
    .i_clr_idx  (wb_rdid_i),
    .i_rs1_idx  (rs1_idx_i),
    .i_rs2_idx  (rs2_idx_i),
    .i_rd_idx   (rd_idx_i),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend),
    .o_rd_pend  (w_rd_pend),
    .o_any_pend (w_any_pend)
  );

  // RAW check uses the pre-clear scoreboard: no regfile bypass of a same-cycle writeback.
  assign w_live    = id_valid_i & ~flush_i;
  assign w_long    = is_long_op(is_load_i, div_en_i);
  assign w_hazard  = w_rs1_pend | w_rs2_pend;
  assign w_waw     = w_long & wben_i & w_rd_pend;
  assign w_struct  = div_en_i & (r_dstate != D_IDLE);
  assign w_drained = ~w_any_pend & (r_dstate == D_IDLE);

  assign w_trap_block = (r_tstate == T_IDLE) ? trap_i : ~w_drained;

  assign stall_o     = w_live & (w_hazard | w_waw | w_struct | w_trap_block);
  assign issue_o     = w_live & ~stall_o;
  assign div_start_o = issue_o & div_en_i;
  assign div_busy_o  = (r_dstate == D_BUSY);
  assign trap_fire_o = (r_tstate == T_DRAIN) & issue_o;
  assign drain_o     = (r_tstate == T_DRAIN) & ~w_drained;
  assign stall_cnt_o = r_stall_cnt;

  assign w_sb_set = issue_o & wben_i & w_long;
  assign w_sb_clr = wb_wren_i & wb_long_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dstate <= D_IDLE;
    end else begin
      case (r_dstate)
        D_IDLE:  if (div_start_o) r_dstate <= D_BUSY;
        D_BUSY:  if (div_done_i)  r_dstate <= D_IDLE;
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  // Losing the held trap (flush or bubble) abandons the drain without firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstate <= T_IDLE;
    end else begin
      case (r_tstate)
        T_IDLE:  if (w_live & trap_i) r_tstate <= T_DRAIN;
        T_DRAIN: if (flush_i | ~id_valid_i | trap_fire_o) r_tstate <= T_IDLE;
        default: r_tstate <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_stall_cnt <= '0;
    else if (stall_o & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: RAW/WAW/structural stalls, divider sequencing, trap drain, reset.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i, wben_i, is_load_i, div_en_i, trap_i, flush_i;
  logic [4:0]  rs1_idx_i, rs2_idx_i, rd_idx_i, wb_rdid_i;
  logic        wb_wren_i, wb_long_i, div_done_i;
  logic        issue_o, stall_o, div_start_o, div_busy_o, trap_fire_o, drain_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  id_issue_ctrl #(.NREG(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .rs1_idx_i(rs1_idx_i),
    .rs2_idx_i(rs2_idx_i), .rd_idx_i(rd_idx_i), .wben_i(wben_i), .is_load_i(is_load_i),
    .div_en_i(div_en_i), .trap_i(trap_i), .flush_i(flush_i), .wb_wren_i(wb_wren_i),
    .wb_rdid_i(wb_rdid_i), .wb_long_i(wb_long_i), .div_done_i(div_done_i),
    .issue_o(issue_o), .stall_o(stall_o), .div_start_o(div_start_o),
    .div_busy_o(div_busy_o), .trap_fire_o(trap_fire_o), .drain_o(drain_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_io(input string tag, input logic ei, input logic es);
    chk({tag, ".issue"}, {31'b0, issue_o}, {31'b0, ei});
    chk({tag, ".stall"}, {31'b0, stall_o}, {31'b0, es});
    if (es) exp_cnt++;
  endtask

  task automatic clr_in();
    id_valid_i = 0; rs1_idx_i = 0; rs2_idx_i = 0; rd_idx_i = 0; wben_i = 0;
    is_load_i = 0; div_en_i = 0; trap_i = 0; flush_i = 0;
    wb_wren_i = 0; wb_rdid_i = 0; wb_long_i = 0; div_done_i = 0;
  endtask

  // Advance to the next negedge with all inputs idle; caller then drives and checks.
  task automatic nxt();
    @(negedge clk);
    clr_in();
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wb, input logic ld, input logic dv);
    id_valid_i = 1; rs1_idx_i = rs1; rs2_idx_i = rs2; rd_idx_i = rd;
    wben_i = wb; is_load_i = ld; div_en_i = dv;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_wren_i = 1; wb_rdid_i = rd; wb_long_i = 1;
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    #1;
    chk("rst.issue", {31'b0, issue_o}, 32'd0);
    chk("rst.stall", {31'b0, stall_o}, 32'd0);
    chk("rst.busy",  {31'b0, div_busy_o}, 32'd0);
    chk("rst.drain", {31'b0, drain_o}, 32'd0);
    chk("rst.cnt",   stall_cnt_o, 32'd0);
    nxt(); nxt();
    rst_n = 1;

    // Load x5 then dependent add: stalls until one cycle after the clearing writeback
    nxt(); instr(0, 0, 5, 1, 1, 0); #1; expect_io("ld5", 1, 0);
    nxt(); instr(5, 1, 6, 1, 0, 0); #1; expect_io("raw.c1", 0, 1);
    nxt(); instr(5, 1, 6, 1, 0, 0); #1; expect_io("raw.c2", 0, 1);
    nxt(); instr(5, 1, 6, 1, 0, 0); wb(5); #1; expect_io("raw.wb", 0, 1);
    nxt(); instr(5, 1, 6, 1, 0, 0); #1;
    chk("raw.cnt", stall_cnt_o, exp_cnt);
    chk("raw.cnt3", stall_cnt_o, 32'd3);
    expect_io("raw.go", 1, 0);

    // Divider: start pulse, structural stall for second div, restart after done
    nxt(); instr(1, 2, 7, 1, 0, 1); #1;
    expect_io("div1", 1, 0);
    chk("div1.start", {31'b0, div_start_o}, 32'd1);
    nxt(); instr(3, 4, 8, 1, 0, 1); #1;
    expect_io("div2.c1", 0, 1);
    chk("div2.busy",  {31'b0, div_busy_o}, 32'd1);
    chk("div2.start", {31'b0, div_start_o}, 32'd0);
    nxt(); instr(3, 4, 8, 1, 0, 1); div_done_i = 1; #1;
    expect_io("div2.done", 0, 1);
    nxt(); instr(3, 4, 8, 1, 0, 1); #1;
    expect_io("div2.go", 1, 0);
    chk("div2.start2", {31'b0, div_start_o}, 32'd1);
    chk("div.cnt", stall_cnt_o, exp_cnt);
    nxt(); div_done_i = 1; wb(8); #1;
    chk("div.busy_hold", {31'b0, div_busy_o}, 32'd1);
    nxt(); wb(7);
    nxt(); #1;
    chk("div.idle", {31'b0, div_busy_o}, 32'd0);

    // x0 is never tracked
    nxt(); instr(0, 0, 0, 1, 1, 0); #1; expect_io("ldx0", 1, 0);
    nxt(); instr(0, 0, 0, 1, 1, 0); #1; expect_io("ldx0.waw", 1, 0);

    // WAW on x5, then simultaneous wb x5 + issue of load x5 leaves pend[5] set
    nxt(); instr(0, 0, 5, 1, 1, 0); #1; expect_io("waw.ld1", 1, 0);
    nxt(); instr(0, 0, 5, 1, 1, 0); #1; expect_io("waw.c1", 0, 1);
    nxt(); instr(0, 0, 5, 1, 1, 0); wb(5); #1; expect_io("waw.wb", 0, 1);
    nxt(); instr(0, 0, 5, 1, 1, 0); #1; expect_io("waw.go", 1, 0);
    nxt(); wb(5);
    nxt(); instr(0, 0, 5, 1, 1, 0); wb(5); #1; expect_io("setwin.ld", 1, 0);
    nxt(); instr(0, 5, 9, 1, 0, 0); #1; expect_io("setwin.use", 0, 1);
    nxt(); wb(5);
    nxt(); instr(0, 5, 9, 1, 0, 0); #1; expect_io("setwin.go", 1, 0);

    // ecall with a load pending: drain until writeback, then fire once
    nxt(); instr(0, 0, 9, 1, 1, 0); #1; expect_io("trap.ld9", 1, 0);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    expect_io("trap.c1", 0, 1);
    chk("trap.c1.fire", {31'b0, trap_fire_o}, 32'd0);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    expect_io("trap.c2", 0, 1);
    chk("trap.c2.drain", {31'b0, drain_o}, 32'd1);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; wb(9); #1;
    expect_io("trap.wb", 0, 1);
    chk("trap.wb.drain", {31'b0, drain_o}, 32'd1);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    expect_io("trap.fire", 1, 0);
    chk("trap.fire.f", {31'b0, trap_fire_o}, 32'd1);
    nxt(); #1;
    chk("trap.after", {31'b0, trap_fire_o}, 32'd0);

    // ecall with nothing outstanding fires on its second cycle
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    expect_io("trap0.c1", 0, 1);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    expect_io("trap0.c2", 1, 0);
    chk("trap0.fire", {31'b0, trap_fire_o}, 32'd1);
    chk("trap.cnt", stall_cnt_o, exp_cnt);

    // Flush during drain abandons the trap; scoreboard keeps x10 pending
    nxt(); instr(0, 0, 10, 1, 1, 0); #1; expect_io("fl.ld10", 1, 0);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1; expect_io("fl.c1", 0, 1);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; #1;
    chk("fl.drain", {31'b0, drain_o}, 32'd1);
    expect_io("fl.c2", 0, 1);
    nxt(); instr(0, 0, 0, 0, 0, 0); trap_i = 1; flush_i = 1; #1;
    expect_io("fl.kill", 0, 0);
    chk("fl.kill.fire", {31'b0, trap_fire_o}, 32'd0);
    nxt(); #1;
    chk("fl.idle.drain", {31'b0, drain_o}, 32'd0);
    nxt(); instr(10, 0, 11, 1, 0, 0); #1; expect_io("fl.pend10", 0, 1);

    // Reset while divider busy and x10 pending
    nxt(); instr(1, 0, 12, 1, 0, 1); #1; expect_io("rst.div", 1, 0);
    nxt(); #1;
    chk("rst.pre.busy", {31'b0, div_busy_o}, 32'd1);
    rst_n = 0; exp_cnt = 0; #1;
    chk("rst.mid.busy", {31'b0, div_busy_o}, 32'd0);
    chk("rst.mid.cnt",  stall_cnt_o, 32'd0);
    chk("rst.mid.sb",   dut.u_sb.r_pend, 32'd0);
    nxt(); rst_n = 1;
    nxt(); instr(10, 12, 13, 1, 0, 0); #1; expect_io("rst.nopend", 1, 0);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
